// File: rtl/kpt_stream_out.sv
// rtl/kpt_stream_out.sv - keypoint memory readout streamer; optional checksum beat under KPT_STREAM_CHECKSUM_EN
module kpt_stream_out #(
  parameter int KPT_DEPTH = 2000,
  parameter int ADDR_W    = 11,
  parameter int KPT_W     = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] kpt1_count,
  input  logic [ADDR_W-1:0] kpt2_count,
  output logic              mem1_en,
  output logic [ADDR_W-1:0] mem1_addr,
  input  logic [KPT_W-1:0]  mem1_dout,
  output logic              mem2_en,
  output logic [ADDR_W-1:0] mem2_addr,
  input  logic [KPT_W-1:0]  mem2_dout,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WAITM,
    S_ROW,
    S_COL,
    S_TRL,
`ifdef KPT_STREAM_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_C  = ADDR_W'(KPT_DEPTH);
  localparam logic [ADDR_W-1:0] ONE_C    = ADDR_W'(1);
  localparam logic [15:0]       TRL_WORD = 16'hFFFF;

  state_t              state_q, state_d;
  logic                layer_q, layer_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   cnt1_q, cnt1_d;
  logic [ADDR_W-1:0]   cnt2_q, cnt2_d;
  logic [KPT_W-1:0]    kpt_q, kpt_d;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                mem1_en_q, mem1_en_d;
  logic                mem2_en_q, mem2_en_d;
  logic [ADDR_W-1:0]   mem1_addr_q, mem1_addr_d;
  logic [ADDR_W-1:0]   mem2_addr_q, mem2_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef KPT_STREAM_CHECKSUM_EN
  logic [15:0]         chk_q, chk_d;
`endif

  logic                xfer;
  logic [ADDR_W-1:0]   cur_cnt;
  logic [KPT_W-1:0]    dout_sel;
  logic                fetch_go;
  logic [ADDR_W-1:0]   fetch_addr;

  // Counts beyond the memory depth are clamped; the clamped value is both read and reported.
  function automatic logic [ADDR_W-1:0] clamp_cnt(input logic [ADDR_W-1:0] c);
    return (c > DEPTH_C) ? DEPTH_C : c;
  endfunction

  function automatic logic [15:0] hdr_word(input logic layer, input logic [ADDR_W-1:0] c);
    return {4'hA, layer, 11'(c)};
  endfunction

  function automatic logic [15:0] row_word(input logic [KPT_W-1:0] k);
    return {7'b0, k[18:10]};
  endfunction

  function automatic logic [15:0] col_word(input logic [KPT_W-1:0] k);
    return {6'b0, k[9:0]};
  endfunction

  assign xfer     = out_valid_q && out_ready;
  assign cur_cnt  = layer_q ? cnt2_q : cnt1_q;
  assign dout_sel = layer_q ? mem2_dout : mem1_dout;

  // Next-state and next-output computation; every output is registered so the pins are glitch-free.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    idx_d       = idx_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    kpt_d       = kpt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem1_en_d   = 1'b0;
    mem2_en_d   = 1'b0;
    mem1_addr_d = mem1_addr_q;
    mem2_addr_d = mem2_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fetch_go    = 1'b0;
    fetch_addr  = idx_q;
`ifdef KPT_STREAM_CHECKSUM_EN
    chk_d       = xfer ? (chk_q ^ out_data_q) : chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt1_d      = clamp_cnt(kpt1_count);
          cnt2_d      = clamp_cnt(kpt2_count);
          layer_d     = 1'b0;
          idx_d       = '0;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = hdr_word(1'b0, clamp_cnt(kpt1_count));
`ifdef KPT_STREAM_CHECKSUM_EN
          chk_d       = '0;
`endif
          state_d     = S_HDR;
        end
      end

      S_HDR: begin
        if (xfer) begin
          if (cur_cnt == '0) begin
            if (!layer_q) begin
              // Empty layer 1: go straight to the layer-2 header.
              layer_d    = 1'b1;
              idx_d      = '0;
              out_data_d = hdr_word(1'b1, cnt2_q);
              state_d    = S_HDR;
            end else begin
              out_data_d = TRL_WORD;
              state_d    = S_TRL;
            end
          end else begin
            out_valid_d = 1'b0;
            fetch_go    = 1'b1;
            fetch_addr  = idx_q;
            state_d     = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        state_d = S_WAITM;
      end

      S_WAITM: begin
        // Read data is valid now; keep it for the COL word and present the ROW word.
        kpt_d       = dout_sel;
        out_valid_d = 1'b1;
        out_data_d  = row_word(dout_sel);
        state_d     = S_ROW;
      end

      S_ROW: begin
        if (xfer) begin
          out_data_d = col_word(kpt_q);
          state_d    = S_COL;
        end
      end

      S_COL: begin
        if (xfer) begin
          idx_d = idx_q + ONE_C;
          if (idx_q == cur_cnt - ONE_C) begin
            if (!layer_q) begin
              layer_d    = 1'b1;
              idx_d      = '0;
              out_data_d = hdr_word(1'b1, cnt2_q);
              state_d    = S_HDR;
            end else begin
              out_data_d = TRL_WORD;
              state_d    = S_TRL;
            end
          end else begin
            out_valid_d = 1'b0;
            fetch_go    = 1'b1;
            fetch_addr  = idx_q + ONE_C;
            state_d     = S_FETCH;
          end
        end
      end

      S_TRL: begin
        if (xfer) begin
`ifdef KPT_STREAM_CHECKSUM_EN
          // Checksum covers HDR through TRL, so fold the trailer in here.
          out_data_d = chk_q ^ out_data_q;
          state_d    = S_CHK;
`else
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_FIN;
`endif
        end
      end

`ifdef KPT_STREAM_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_FIN;
        end
      end
`endif

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // One-cycle read strobe on the memory of the current layer.
    if (fetch_go) begin
      if (layer_q) begin
        mem2_en_d   = 1'b1;
        mem2_addr_d = fetch_addr;
      end else begin
        mem1_en_d   = 1'b1;
        mem1_addr_d = fetch_addr;
      end
    end
  end

  // State and output registers; reset abandons any readout in progress.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= 1'b0;
      idx_q       <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      kpt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mem1_en_q   <= 1'b0;
      mem2_en_q   <= 1'b0;
      mem1_addr_q <= '0;
      mem2_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef KPT_STREAM_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      idx_q       <= idx_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      kpt_q       <= kpt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mem1_en_q   <= mem1_en_d;
      mem2_en_q   <= mem2_en_d;
      mem1_addr_q <= mem1_addr_d;
      mem2_addr_q <= mem2_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef KPT_STREAM_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign mem1_en   = mem1_en_q;
  assign mem1_addr = mem1_addr_q;
  assign mem2_en   = mem2_en_q;
  assign mem2_addr = mem2_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/kpt_stream_out.md
Name: kpt_stream_out

Overview:
- Readout engine for the two keypoint memories (layer 1 and layer 2) filled by the keypoint detect/filter stage.
- On a start pulse, reads each stored keypoint and streams it off-chip over the CORE 16-bit out_valid/out_data port with a valid/ready handshake.
- Replaces the hierarchical backdoor dump of the keypoint memories, so gate-level and post-layout runs can check keypoints at the pins.

Parameters:
- KPT_DEPTH, 2000, entries per keypoint memory
- ADDR_W, 11, keypoint memory address width
- KPT_W, 19, keypoint entry width; row = [18:10] (9 bits), col = [9:0] (10 bits)

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous reset, active-high (1 = reset asserted)
- start  input  1  one-cycle pulse, driven from detect_filter_done
- kpt1_count  input  ADDR_W  number of valid layer-1 entries
- kpt2_count  input  ADDR_W  number of valid layer-2 entries
- mem1_en  output  1  layer-1 memory read enable
- mem1_addr  output  ADDR_W  layer-1 read address
- mem1_dout  input  KPT_W  layer-1 read data, valid 1 cycle after mem1_en
- mem2_en  output  1  layer-2 memory read enable
- mem2_addr  output  ADDR_W  layer-2 read address
- mem2_dout  input  KPT_W  layer-2 read data, valid 1 cycle after mem2_en
- out_ready  input  1  sink accepts a beat
- out_valid  output  1  out_data is valid
- out_data  output  16  stream word
- busy  output  1  readout in progress
- done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset values: out_valid, out_data, mem1_en, mem2_en, busy and done = 0; mem1_addr and mem2_addr = 0; FSM in IDLE. Reset is honoured asynchronously in any state; a readout in progress is abandoned, not resumed.
- Beat transfer: a beat transfers when out_valid && out_ready. While out_valid=1 and out_ready=0, out_data is held stable and out_valid stays 1.
- Stream format, in order:
  - HDR word per layer: {4'hA, 1'b layer (0 = layer 1, 1 = layer 2), 11'b count}.
  - Per keypoint, a ROW word {7'b0, row[8:0]}, then a COL word {6'b0, col[9:0]}.
  - After layer 2, a TRL word 16'hFFFF.
  - Sequence: HDR(L1), kpts L1, HDR(L2), kpts L2, TRL.
- Count clamp: a count greater than KPT_DEPTH is clamped to KPT_DEPTH. The clamped value is the one used for reading and is the one reported in HDR.
- FSM states: IDLE, HDR, FETCH, WAITM, ROW, COL, TRL, FIN.
- IDLE:
  - On start=1, latch both clamped counts, set layer=0 and idx=0, raise busy, go to HDR.
  - start while busy=1 is ignored.
- HDR: out_valid=1. On transfer: if the count for this layer is 0, go to HDR (layer 2) or TRL (after layer 2); otherwise go to FETCH.
- FETCH:
  - Assert memX_en for exactly 1 cycle with memX_addr=idx, X selected by layer.
  - out_valid=0.
  - Go to WAITM.
- WAITM: capture memX_dout into the keypoint register; out_valid=0; go to ROW.
- ROW: out_valid=1; on transfer go to COL.
- COL: out_valid=1. On transfer, idx++. If idx == count-1 before the increment:
  - layer 0: set layer=1, idx=0, go to HDR.
  - layer 1: go to TRL.
  - Otherwise go to FETCH.
- TRL: out_valid=1; on transfer go to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Timing: busy rises the cycle after start is sampled. HDR out_valid rises in that same cycle. Exactly 2 idle cycles (FETCH, WAITM) precede every ROW beat.
- Total beats = 3 + 2·(n1+n2), or 4 + 2·(n1+n2) with the optional feature.

Optional Feature:
- Macro: KPT_STREAM_CHECKSUM_EN.
- Defined:
  - A 16-bit running XOR of every transferred word is kept, cleared at start.
  - After TRL, one extra CHK beat carries that XOR (HDR through TRL inclusive), then FIN.
- Undefined: no CHK state and no checksum register; FIN follows TRL directly.

Test Plan:
- L1 = {(5,7),(479,639)}, L2 = {(0,1)}, counts 2/1, out_ready=1. Required stream: A002, 0005, 0007, 01DF, 027F, A801, 0000, 0001, FFFF. Then done pulses once and busy falls in the same cycle.
- Same stimulus with out_ready toggling 1/0 every cycle. Same word sequence required, and out_data must be unchanged throughout every stalled cycle.
- Counts 0/0 → stream A000, A800, FFFF; mem1_en and mem2_en never assert.
- kpt1_count=2047 → HDR = A7D0 (2000); exactly 2000 ROW/COL pairs; highest mem1_addr issued = 1999.
- Assert rst_n mid-layer-1 → all outputs 0 at the next edge. A following start gives a complete fresh stream from HDR(L1). A start pulsed while busy must not alter the stream.
- With KPT_STREAM_CHECKSUM_EN and the first case's data → 10th beat = XOR of the 9 words above, then done.
